// File: rtl/next_pc_unit.sv
// Fetch PC generator: sequential increment, stall hold, resolved-branch redirect and sticky misalignment flag.
// Optional return-address stack is built only when NEXT_PC_RAS_EN is defined.
module next_pc_unit #(
   parameter int unsigned              WordSize = 32,
   parameter logic [WordSize-1:0]      ResetPC  = '0,
   parameter int unsigned              PCStep   = 4,
   parameter int unsigned              RasDepth = 4
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          stall,
   input  logic                          branch_valid,
   input  logic                          branch_taken,
   input  logic                          addr_mode,
   input  logic                          is_call,
   input  logic                          is_ret,
   input  logic [WordSize-1:0]           imm,
   input  logic [WordSize-1:0]           rs1d,
   input  logic [WordSize-1:0]           branch_pc,
   output logic [WordSize-1:0]           pc,
   output logic [WordSize-1:0]           branch_addr,
   output logic                          redirect,
   output logic                          misalign_err,
   output logic [$clog2(RasDepth):0]     ras_count
);

   localparam int unsigned PtrW = $clog2(RasDepth);
   localparam int unsigned CntW = PtrW + 1;

   logic [WordSize-1:0] pc_q, pc_d;
   logic                redirect_q, misalign_q;
   logic [WordSize-1:0] target;
   logic [WordSize-1:0] regSum;
   logic                takenEv, aligned, accept;

   assign takenEv     = branch_valid & branch_taken;
   assign regSum      = rs1d + imm;
   assign branch_addr = addr_mode ? {regSum[WordSize-1:1], 1'b0} : (branch_pc + imm);

`ifdef NEXT_PC_RAS_EN
   logic [WordSize-1:0] ras_q [RasDepth];
   logic [PtrW-1:0]     rasPtr_q, rasPtr_d, topIdx, wrIdx;
   logic [CntW-1:0]     rasCount_q, rasCount_d;
   logic                popValid, wrEn;
   logic [WordSize-1:0] link;

   // rasPtr_q is the next free slot; once full it also points at the oldest entry
   assign topIdx   = rasPtr_q - PtrW'(1);
   assign popValid = takenEv & is_ret & (rasCount_q != '0);
   assign target   = popValid ? ras_q[topIdx] : branch_addr;
   assign link     = branch_pc + WordSize'(PCStep);

   always_comb begin
      rasPtr_d   = rasPtr_q;
      rasCount_d = rasCount_q;
      wrEn       = 1'b0;
      wrIdx      = rasPtr_q;
      if (accept) begin
         if (popValid && is_call) begin
            wrEn  = 1'b1;
            wrIdx = topIdx;
         end else if (popValid) begin
            rasPtr_d   = topIdx;
            rasCount_d = rasCount_q - CntW'(1);
         end else if (is_call) begin
            wrEn     = 1'b1;
            rasPtr_d = rasPtr_q + PtrW'(1);
            if (rasCount_q != CntW'(RasDepth)) begin
               rasCount_d = rasCount_q + CntW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wrEn) begin
         ras_q[wrIdx] <= link;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rasPtr_q   <= '0;
         rasCount_q <= '0;
      end else begin
         rasPtr_q   <= rasPtr_d;
         rasCount_q <= rasCount_d;
      end
   end

   assign ras_count = rasCount_q;
`else
   logic unusedRasInputs;
   assign unusedRasInputs = is_call ^ is_ret;
   assign target          = branch_addr;
   assign ras_count       = '0;
`endif

   assign aligned = (target[1:0] == 2'b00);
   assign accept  = takenEv & aligned;

   // A taken event (even misaligned) overrides stall; misaligned holds PC
   always_comb begin
      pc_d = pc_q;
      if (accept) begin
         pc_d = target;
      end else if (!takenEv && !stall) begin
         pc_d = pc_q + WordSize'(PCStep);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_q       <= ResetPC;
         redirect_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         redirect_q <= accept;
         misalign_q <= misalign_q | (takenEv & ~aligned);
      end
   end

   assign pc           = pc_q;
   assign redirect     = redirect_q;
   assign misalign_err = misalign_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed scenarios then randomized traffic
// compared against a queue-based behavioural model.
module tb_next_pc_unit;

   localparam int W     = 32;
   localparam int Depth = 4;
`ifdef NEXT_PC_RAS_EN
   localparam bit RasEn = 1'b1;
`else
   localparam bit RasEn = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         stall = 1'b0, branch_valid = 1'b0, branch_taken = 1'b0;
   logic         addr_mode = 1'b0, is_call = 1'b0, is_ret = 1'b0;
   logic [W-1:0] imm = '0, rs1d = '0, branch_pc = '0;
   logic [W-1:0] pc, branch_addr;
   logic         redirect, misalign_err;
   logic [2:0]   ras_count;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] mPc;
   logic         mRedir, mMis;
   logic [W-1:0] rasQ[$];

   next_pc_unit #(
      .WordSize(W), .ResetPC('0), .PCStep(4), .RasDepth(Depth)
   ) dut (
      .clk(clk), .rstn(rstn), .stall(stall),
      .branch_valid(branch_valid), .branch_taken(branch_taken),
      .addr_mode(addr_mode), .is_call(is_call), .is_ret(is_ret),
      .imm(imm), .rs1d(rs1d), .branch_pc(branch_pc),
      .pc(pc), .branch_addr(branch_addr), .redirect(redirect),
      .misalign_err(misalign_err), .ras_count(ras_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, "_pc"}, pc, mPc);
      checkOutput({tag, "_redirect"}, W'(redirect), W'(mRedir));
      checkOutput({tag, "_misalign"}, W'(misalign_err), W'(mMis));
      checkOutput({tag, "_count"}, W'(ras_count), RasEn ? W'(rasQ.size()) : '0);
   endtask

   function automatic logic [W-1:0] modelBa(input logic md, input logic [W-1:0] im,
                                            input logic [W-1:0] r1, input logic [W-1:0] bp);
      logic [W-1:0] s;
      if (md) begin
         s = r1 + im;
         return s & ~W'(1);
      end
      return bp + im;
   endfunction

   task automatic applyStimulus(input string tag, input logic st, input logic bv, input logic bt,
                                input logic md, input logic call, input logic ret,
                                input logic [W-1:0] im, input logic [W-1:0] r1, input logic [W-1:0] bp);
      logic [W-1:0] ba, tgt;
      logic         taken;
      stall = st; branch_valid = bv; branch_taken = bt; addr_mode = md;
      is_call = call; is_ret = ret; imm = im; rs1d = r1; branch_pc = bp;
      #1;
      ba = modelBa(md, im, r1, bp);
      checkOutput({tag, "_branch_addr"}, branch_addr, ba);
      @(posedge clk);
      #1;
      taken = bv && bt;
      tgt   = ba;
      if (RasEn && taken && ret && rasQ.size() > 0) tgt = rasQ[$];
      if (taken && tgt[1:0] == 2'b00) begin
         mPc    = tgt;
         mRedir = 1'b1;
         if (RasEn) begin
            if (ret && rasQ.size() > 0) void'(rasQ.pop_back());
            if (call) begin
               if (rasQ.size() == Depth) void'(rasQ.pop_front());
               rasQ.push_back(bp + 4);
            end
         end
      end else begin
         mRedir = 1'b0;
         if (taken) mMis = 1'b1;
         else if (!st) mPc = mPc + 4;
      end
      checkState(tag);
   endtask

   task automatic idle(input string tag);
      applyStimulus(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic applyReset(input string tag);
      stall = 1'b0; branch_valid = 1'b0; branch_taken = 1'b0;
      is_call = 1'b0; is_ret = 1'b0;
      rstn = 1'b0;
      #1;
      mPc = '0; mRedir = 1'b0; mMis = 1'b0;
      rasQ.delete();
      checkState(tag);
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      logic [W-1:0] rimm, rrs, rbp;
      applyReset("por");

      // Free-running fetch after reset release
      idle("seq1");
      idle("seq2");
      idle("seq3");
      checkOutput("seq_pc_c", pc, 32'hC);

      // Taken event wins over stall, then redirect drops while stalled
      applyStimulus("stall_br", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, '0, 32'h100);
      checkOutput("stall_br_pc", pc, 32'h120);
      checkOutput("stall_br_redir", W'(redirect), 32'h1);
      applyStimulus("stall_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      applyStimulus("not_taken", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, '0, 32'h200);

      // Reset asserted while a redirect pulse is in flight
      applyStimulus("pre_rst", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, '0, 32'h100);
      applyReset("mid_rst");
      checkOutput("mid_rst_pc", pc, 32'h0);
      idle("post_rst");

      // Register-relative target and a misaligned one
      applyStimulus("mode1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1, 32'h203, '0);
      checkOutput("mode1_pc", pc, 32'h204);
      applyStimulus("misal", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h2, 32'h200, '0);
      checkOutput("misal_flag", W'(misalign_err), 32'h1);
      checkOutput("misal_pc", pc, 32'h204);
      idle("misal_sticky");
      applyReset("rst2");

      if (RasEn) begin
         for (int i = 1; i <= 5; i++)
            applyStimulus("call", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, '0, W'(i * 16));
         checkOutput("ras_full", W'(ras_count), 32'h4);
         applyStimulus("ret1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, '0, 32'h200);
         checkOutput("ret1_pc", pc, 32'h54);
         applyStimulus("ret2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, '0, 32'h200);
         applyStimulus("ret3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, '0, 32'h200);
         applyStimulus("ret4", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, '0, 32'h200);
         checkOutput("ret4_pc", pc, 32'h24);
         applyStimulus("ret5", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, '0, 32'h200);
         checkOutput("ret5_pc", pc, 32'h300);
         applyStimulus("callret_a", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, '0, 32'h10);
         applyStimulus("callret_b", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, '0, 32'h80);
         checkOutput("callret_pc", pc, 32'h14);
         applyStimulus("callret_c", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, '0, 32'h200);
         checkOutput("callret_top", pc, 32'h84);
         applyReset("rst3");
      end

      // Randomized traffic, mostly aligned targets so the sticky flag stays informative
      for (int n = 0; n < 400; n++) begin
         if (n % 50 == 49) applyReset("rnd_rst");
         rbp  = $urandom & 32'hFFFF_FFFC;
         rimm = ($urandom_range(0, 9) == 0) ? W'($urandom) : ($urandom & 32'h0000_FFFC);
         rrs  = $urandom;
         applyStimulus("rnd", 1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                       1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), rimm, rrs, rbp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
